// File: rtl/fp_accum_seq.sv
// fp_accum_seq: feeds a float stream through an external fpadd, one add at a time.
// Define FPACC_TIMEOUT_EN to add a WAIT-state watchdog with sticky acc_err.
module fp_accum_seq #(
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             acc_valid,
  output logic [31:0]      acc_result,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_err
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    OUT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      elem_q, elem_d;
  logic [31:0]      res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             last_q, last_d;
  logic             rdy_q, rdy_d;
  logic             start_q, start_d;
  logic             vld_q, vld_d;
  logic             tmo;

`ifdef FPACC_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  assign tmo = (state_q == WAIT) && !add_done
            && (wd_q == TW'(TMO_CYC - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q | tmo;
    if (state_q == WAIT && !add_done)
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign acc_err = err_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^TMO_CYC;
  assign tmo        = 1'b0;
  assign acc_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    elem_d  = elem_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    start_d = 1'b0;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rdy_q && in_valid) begin
          elem_d = in_data;
          last_d = in_last;
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          // first element seeds the accumulator without an add
          if (cnt_q == '0) begin
            acc_d = in_data;
            if (in_last)
              state_d = OUT;
          end else begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (add_done) begin
          acc_d   = add_sum;
          state_d = last_q ? OUT : IDLE;
        end else if (tmo) begin
          state_d = OUT;
        end
      end
      OUT: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OUT) begin
      vld_d  = 1'b1;
      res_d  = acc_d;
      rcnt_d = cnt_d;
    end
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      elem_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      elem_q  <= elem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready   = rdy_q;
  assign add_start  = start_q;
  assign add_a      = acc_q;
  assign add_b      = elem_q;
  assign acc_valid  = vld_q;
  assign acc_result = res_q;
  assign acc_count  = rcnt_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: drives float streams into fp_accum_seq with a model fpadd.
// Expected sums come from integer arithmetic converted to IEEE-754 bits.
module tb_fp_accum_seq;
  localparam int CW  = 3;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, add_start, acc_valid, acc_err;
  logic [31:0]   add_a, add_b, acc_result;
  logic [31:0]   add_sum = '0;
  logic          add_done = 1'b0;
  logic [CW-1:0] acc_count;

  int errors = 0, checks = 0;
  int lat = 3, cnt_a = 0, drop = 0, starts = 0;
  int hs_to = 0, rp = 0;
  bit stuck = 0, stale = 0, man_done = 0;
  logic [31:0] man_sum = '0, pa = '0, pb = '0;
  logic [31:0]   rq[$];
  logic [CW-1:0] cq[$];

  always #5 clk = ~clk;

  fp_accum_seq #(.CNT_W(CW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .add_start(add_start), .add_a(add_a),
    .add_b(add_b), .add_sum(add_sum),
    .add_done(add_done), .acc_valid(acc_valid),
    .acc_result(acc_result), .acc_count(acc_count),
    .acc_err(acc_err)
  );

  function automatic real to_real(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_bits(input real r);
    real a;
    int  e;
    logic [22:0] m;
    if (r == 0.0) return 32'h0;
    a = (r < 0.0) ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {r < 0.0, e[7:0], m};
  endfunction

  // fpadd model: done stays high until the next start; optional late drop
  always @(negedge clk) begin
    if (add_start) begin
      pa = add_a; pb = add_b; cnt_a = lat;
      drop = stale ? 3 : 1;
      starts++;
    end
    if (drop > 0) begin
      drop--;
      if (drop == 0) add_done = 1'b0;
    end
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0 && !stuck) begin
        add_sum  = to_bits(to_real(pa) + to_real(pb));
        add_done = 1'b1;
      end
    end
    if (man_done) begin
      add_sum  = man_sum;
      add_done = 1'b1;
    end
    if (acc_valid) begin
      rq.push_back(acc_result);
      cq.push_back(acc_count);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      in_data = $urandom;
      in_last = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= 400) hs_to++;
    in_data = d;
    in_last = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok, output logic [31:0] r,
                          output logic [CW-1:0] c);
    int n = 0;
    while (rq.size() <= rp && n < 500) begin tick(); n++; end
    ok = rq.size() > rp;
    r  = ok ? rq[rp] : 32'hx;
    c  = ok ? cq[rp] : 'x;
    if (ok) rp++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, add_start, acc_valid, acc_err} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {in_ready, add_start, acc_valid, acc_err});
    end
    checks++;
    if ({add_a, add_b} !== 64'h0) begin
      errors++;
      $display("FAIL rst_ops got %h/%h want 0", add_a, add_b);
    end
    checks++;
    if (acc_result !== 32'h0 || acc_count !== '0) begin
      errors++;
      $display("FAIL rst_res got %h/%0d want 0", acc_result, acc_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pre_clk got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rdy_post_clk got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int s0 = starts;
    send(32'h40490FDB, 1'b1);
    checks++;
    if (acc_valid !== 1'b1 || acc_result !== 32'h40490FDB
        || acc_count !== CW'(1)) begin
      errors++;
      $display("FAIL single got v=%b %h/%0d want 1 40490fdb/1",
               acc_valid, acc_result, acc_count);
    end
    rp = rq.size();
    tick();
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got %b want 0", acc_valid);
    end
    tick(); tick();
    checks++;
    if (acc_result !== 32'h40490FDB || starts !== s0) begin
      errors++;
      $display("FAIL single_hold got %h starts=%0d want 40490fdb 0",
               acc_result, starts - s0);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    int s0 = starts;
    lat = 3;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    checks++;
    if (add_start !== 1'b1 || add_a !== 32'h3F800000
        || add_b !== 32'h40000000) begin
      errors++;
      $display("FAIL issue got s=%b a=%h b=%h want 1 3f800000 40000000",
               add_start, add_a, add_b);
    end
    tick();
    checks++;
    if (add_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse got %b want 0", add_start);
    end
    send(32'h3F000000, 1'b1);
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h40600000 || c !== CW'(3)) begin
      errors++;
      $display("FAIL basic got ok=%b %h/%0d want 40600000/3", ok, r, c);
    end
    checks++;
    if (starts - s0 !== 2) begin
      errors++;
      $display("FAIL basic_starts got %0d want 2", starts - s0);
    end
  endtask

  task automatic test_cancel();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    send(32'h40400000, 1'b0);
    send(32'hC0400000, 1'b1);
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h0 || c !== CW'(2)) begin
      errors++;
      $display("FAIL cancel got ok=%b %h/%0d want 0/2", ok, r, c);
    end
  endtask

  task automatic test_stale();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    stale = 1; lat = 5;
    send(32'h40A00000, 1'b0);
    send(32'h40C00000, 1'b1);
    checks++;
    if (add_a !== 32'h40A00000 || add_b !== 32'h40C00000) begin
      errors++;
      $display("FAIL stale_ops got %h %h want 40a00000 40c00000",
               add_a, add_b);
    end
    tick();
    checks++;
    if (acc_valid !== 1'b0 || in_ready !== 1'b0
        || add_a !== 32'h40A00000 || add_b !== 32'h40C00000) begin
      errors++;
      $display("FAIL stale_settle got v=%b r=%b a=%h b=%h",
               acc_valid, in_ready, add_a, add_b);
    end
    tick();
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_early got %b want 0", acc_valid);
    end
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h41300000 || c !== CW'(2)) begin
      errors++;
      $display("FAIL stale got ok=%b %h/%0d want 41300000/2", ok, r, c);
    end
    stale = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    lat = 30;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, add_start, acc_valid, acc_err} !== 4'b0
        || {add_a, add_b, acc_result} !== 96'h0
        || acc_count !== '0) begin
      errors++;
      $display("FAIL mid_rst got r=%b a=%h b=%h res=%h",
               in_ready, add_a, add_b, acc_result);
    end
    tick();
    reset = 1'b0;
    repeat (40) tick();
    checks++;
    if (rq.size() !== rp || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_done got outs=%0d rdy=%b want 0 1",
               rq.size() - rp, in_ready);
    end
    lat = 3;
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h40000000 || c !== CW'(2)) begin
      errors++;
      $display("FAIL post_rst got ok=%b %h/%0d want 40000000/2", ok, r, c);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    lat = 2;
    for (int i = 0; i < 9; i++)
      send(32'h3F800000, i == 8);
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h41100000 || c !== '1) begin
      errors++;
      $display("FAIL saturate got ok=%b %h/%0d want 41100000/7", ok, r, c);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    for (int s = 0; s < 20; s++) begin
      int len = $urandom_range(1, 6);
      int sum = 0;
      int s0 = starts;
      lat = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        int v = int'($urandom_range(0, 200)) - 100;
        sum += v;
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) tick();
        send(to_bits(real'(v)), i == len - 1);
      end
      wait_out(ok, r, c);
      checks++;
      if (!ok || r !== to_bits(real'(sum)) || c !== CW'(len)) begin
        errors++;
        $display("FAIL rand%0d got ok=%b %h/%0d want %h/%0d",
                 s, ok, r, c, to_bits(real'(sum)), len);
      end
      checks++;
      if (starts - s0 !== len - 1 || acc_err !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_starts got %0d err=%b want %0d 0",
                 s, starts - s0, acc_err, len - 1);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] r;
    logic [CW-1:0] c;
    int n = 0;
    stuck = 1; lat = 3;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
`ifdef FPACC_TIMEOUT_EN
    while (!acc_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n !== TMO + 2) begin
      errors++;
      $display("FAIL tmo_time got %0d want %0d", n, TMO + 2);
    end
    checks++;
    if (acc_err !== 1'b1 || acc_result !== 32'h3F800000
        || acc_count !== CW'(2)) begin
      errors++;
      $display("FAIL tmo_out got e=%b %h/%0d want 1 3f800000/2",
               acc_err, acc_result, acc_count);
    end
    rp = rq.size();
    stuck = 0;
    send(32'h40800000, 1'b1);
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h40800000 || acc_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky got ok=%b %h e=%b want 40800000 1",
               ok, r, acc_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (acc_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear got %b want 0", acc_err);
    end
`else
    while (n < TMO * 15) begin tick(); n++; end
    checks++;
    if (rq.size() !== rp || in_ready !== 1'b0 || acc_err !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo got outs=%0d rdy=%b e=%b want 0 0 0",
               rq.size() - rp, in_ready, acc_err);
    end
    man_sum = 32'h40400000;
    man_done = 1;
    tick();
    man_done = 0;
    wait_out(ok, r, c);
    checks++;
    if (!ok || r !== 32'h40400000 || c !== CW'(2)) begin
      errors++;
      $display("FAIL late_add got ok=%b %h/%0d want 40400000/2", ok, r, c);
    end
    stuck = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_basic();
    test_cancel();
    test_stale();
    test_reset_mid();
    test_saturate();
    test_random();
    test_timeout();
    checks++;
    if (hs_to !== 0) begin
      errors++;
      $display("FAIL handshake got %0d stalls want 0", hs_to);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the element counter.
REQ-002 SHALL have parameter TMO_CYC, default 255, watchdog limit in cycles; used only with FPACC_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  stream element present.
REQ-006 in_data  input  32  IEEE-754 single-precision element.
REQ-007 in_last  input  1  marks final element of the stream; qualified by in_valid.
REQ-008 in_ready  output  1  sequencer accepts in_data this cycle.
REQ-009 add_start  output  1  one-cycle start pulse to the fpadd block.
REQ-010 add_a  output  32  operand a, current accumulator.
REQ-011 add_b  output  32  operand b, captured element.
REQ-012 add_sum  input  32  fpadd result.
REQ-013 add_done  input  1  fpadd completion; level, stays high until the next start.
REQ-014 acc_valid  output  1  one-cycle pulse: acc_result and acc_count valid.
REQ-015 acc_result  output  32  final accumulated sum.
REQ-016 acc_count  output  CNT_W  number of elements summed.
REQ-017 acc_err  output  1  sticky watchdog error flag; constant 0 without FPACC_TIMEOUT_EN.

Function
REQ-018 States SHALL be IDLE, ISSUE, SETTLE, WAIT, OUT.
REQ-019 IDLE: in_ready=1; on in_valid, SHALL capture in_data/in_last and increment count.
REQ-020 IDLE with count==0 (first element): SHALL load acc<=in_data directly, with no adder transaction; if in_last, go to OUT, else stay in IDLE.
REQ-021 IDLE with count>0: SHALL go to ISSUE with the captured element held in add_b.
REQ-022 ISSUE: add_start=1 for exactly one cycle, add_a=acc, add_b=element; next state SETTLE.
REQ-023 SETTLE: SHALL ignore add_done for one cycle, because the stale done from the previous transaction is still high; next state WAIT.
REQ-024 WAIT: on add_done=1, SHALL load acc<=add_sum; if the captured in_last was set, go to OUT, else go to IDLE.
REQ-025 add_a and add_b SHALL stay stable from ISSUE until leaving WAIT.
REQ-026 OUT: acc_valid=1 for one cycle, acc_result=acc, acc_count=count; then SHALL clear acc to 32'h0 and count to 0, and return to IDLE.
REQ-027 in_ready SHALL be 0 in every state except IDLE; elements offered then are not consumed and need not be held stable by the sequencer.
REQ-028 count SHALL saturate at all-ones; further elements are still summed.
REQ-029 acc_result SHALL hold its last value between acc_valid pulses.
REQ-030 Element latency: IDLE accept to next IDLE = 3 + fpadd latency cycles.

Reset
REQ-031 reset SHALL force IDLE immediately, acc=0, count=0, and all outputs 0 (add_start, acc_valid, acc_result, acc_count, acc_err, add_a, add_b); in_ready becomes 1 on the first clock after release.
REQ-032 Reset during WAIT SHALL abandon the transaction; a late add_done SHALL be ignored after reset.

Configuration
REQ-033 Macro FPACC_TIMEOUT_EN defined: a watchdog SHALL count cycles in WAIT; reaching TMO_CYC without add_done SHALL set acc_err=1 (sticky until reset), pulse acc_valid with the current acc, and go through OUT to IDLE.
REQ-034 Macro FPACC_TIMEOUT_EN undefined: there SHALL be no watchdog logic, WAIT SHALL wait indefinitely, and acc_err SHALL be tied to 0.

Verification
REQ-035 The bench, using the fpadd block, SHALL cover: stream 3F800000, 40000000, 3F000000(last) -> acc_valid with acc_result=40600000 (3.5) and acc_count=3.
REQ-036 Single element 40490FDB with in_last -> acc_valid 1 cycle later, acc_result=40490FDB, acc_count=1, add_start never asserted.
REQ-037 Stream 40400000, C0400000(last) -> acc_result=00000000, acc_count=2.
REQ-038 Stale done: hold add_done=1 from the prior sum; check that add_a/add_b update and the new sum is taken only after done falls and rises again (no early capture).
REQ-039 Reset asserted mid-WAIT -> outputs 0 on the same edge, state IDLE; the following stream 3F800000, 3F800000(last) -> acc_result=40000000.
REQ-040 With FPACC_TIMEOUT_EN and add_done stuck at 0 -> acc_err=1 and acc_valid pulse exactly TMO_CYC cycles after entering WAIT.
